// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM state type for the 23-by-12 divider.
package div_pkg;
    localparam int DIVIDEND_W = 23;
    localparam int DIVISOR_W  = 12;
    localparam int ITER_N     = 23;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_rem,
    input  logic                 i_dbit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_rem,
    output logic                 o_qbit
);
    logic [DIVISOR_W:0] w_rem13;
    logic [DIVISOR_W:0] w_dvs13;

    assign w_rem13 = {i_rem[DIVISOR_W-1:0], i_dbit};
    assign w_dvs13 = {1'b0, i_divisor};
    assign o_qbit  = (w_rem13 >= w_dvs13);
    assign o_rem   = o_qbit ? (w_rem13 - w_dvs13) : w_rem13;
endmodule

// File: rtl/div_23_by_12.sv
// Iterative 23-by-12 unsigned restoring divider with valid/ready handshakes.
// Optional DIV_FAST_BYPASS_EN: zero divisor or dividend < divisor finishes in one BUSY cycle.
module div_23_by_12
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(ITER_N - 1);
    localparam logic [DIVIDEND_W-1:0] QUO_DBZ  = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVIDEND_W-1:0] r_quo;
    logic                  r_dbz;

    logic [CNT_W-1:0]      w_idx;
    logic                  w_dbit;
    logic [DIVISOR_W:0]    w_rem_nxt;
    logic                  w_qbit;
    logic                  w_last;
    logic                  w_dvs_zero;
    logic                  w_bypass;
    logic                  w_finish;

    // Dividend is kept intact (needed for the zero-divisor remainder), so bits are picked by counter.
    assign w_idx      = LAST_CNT - r_cnt;
    assign w_dbit     = r_dvd[w_idx];
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_dvs_zero = (r_dvs == '0);

`ifdef DIV_FAST_BYPASS_EN
    assign w_bypass = w_dvs_zero || (r_dvd < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, r_dvs});
`else
    assign w_bypass = 1'b0;
`endif

    assign w_finish = w_last || w_bypass;

    div_step u_step (
        .i_rem     (r_rem),
        .i_dbit    (w_dbit),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: if (w_finish) w_state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_dvd <= dividend;
                    r_dvs <= divisor;
                    r_cnt <= '0;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_dbz <= 1'b0;
                end
                BUSY: begin
                    if (w_finish && w_dvs_zero) begin
                        r_quo <= QUO_DBZ;
                        r_rem <= {1'b0, r_dvd[DIVISOR_W-1:0]};
                        r_dbz <= 1'b1;
                    end else if (w_bypass) begin
                        r_quo <= '0;
                        r_rem <= {1'b0, r_dvd[DIVISOR_W-1:0]};
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[DIVIDEND_W-2:0], w_qbit};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem[DIVISOR_W-1:0];
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_23_by_12.sv
// Self-checking bench for div_23_by_12: directed cases plus a random run against a/b, a%b.
module tb_div_23_by_12;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] dividend = '0;
    logic [11:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] quotient;
    logic [11:0] remainder;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    div_23_by_12 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [22:0] a, input logic [11:0] b);
`ifdef DIV_FAST_BYPASS_EN
        if (b == 0 || 32'(a) < 32'(b)) return 1;
`endif
        return 23;
    endfunction

    // Full transaction: accept, watch latency, check results, hold out_ready low, release.
    task automatic do_op(input logic [22:0] a, input logic [11:0] b, input int hold, input bit full);
        logic [22:0] eq;
        logic [11:0] er;
        logic        ez;
        int          cyc;
        if (b == 0) begin
            eq = 23'h7FFFFF; er = a[11:0]; ez = 1'b1;
        end else begin
            eq = 23'(32'(a) / 32'(b)); er = 12'(32'(a) % 32'(b)); ez = 1'b0;
        end
        if (full) chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; dividend = a; divisor = b;
        tick();
        // Keep offering different operands while busy; they must be ignored.
        dividend = 23'($urandom); divisor = 12'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(exp_lat(a, b)));
        chk("quotient", 64'(quotient), 64'(eq));
        chk("remainder", 64'(remainder), 64'(er));
        chk("div_by_zero", 64'(div_by_zero), 64'(ez));
        if (full) chk("in_ready_done", 64'(in_ready), 64'd0);
        if (b != 0) begin
            n_assert++;
            assert (longint'(quotient) * longint'(b) + longint'(remainder) == longint'(a)
                    && remainder < b) else begin
                n_fail++;
                $error("FAIL identity: q %0h r %0h for a %0h b %0h", quotient, remainder, a, b);
            end
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_quo", 64'(quotient), 64'(eq));
            chk("hold_rem", 64'(remainder), 64'(er));
            chk("hold_dbz", 64'(div_by_zero), 64'(ez));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (full) begin
            chk("release_valid", 64'(out_valid), 64'd0);
            chk("release_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int seen;
        logic [22:0] ra;
        logic [11:0] rb;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quo", 64'(quotient), 64'd0);
        chk("rst_rem", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        tick();

        do_op(23'd100, 12'd7, 0, 1'b1);
        do_op(23'h7FFFFF, 12'hFFF, 0, 1'b1);
        do_op(23'd5, 12'd0, 0, 1'b1);
        do_op(23'd3, 12'd9, 0, 1'b1);
        do_op(23'd1000, 12'd33, 5, 1'b1);
        do_op(23'd8382465, 12'd4095, 0, 1'b1);

        // Reset mid-operation must abort without ever producing a result.
        in_valid = 1'b1; dividend = 23'd100; divisor = 12'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_quo", 64'(quotient), 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        do_op(23'd42, 12'd6, 0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            ra = 23'($urandom & ((32'd1 << $urandom_range(1, 23)) - 1));
            rb = 12'($urandom_range(1, 4095));
            do_op(ra, rb, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
